// File: rtl/accum_arbiter.sv
// accum_arbiter
//   Round-robin owner of a single add/sub accumulator shared by NREQ requesters.
//   Per grant: clear the accumulator, stream the owner's beats into A, then
//   return the final sum and carry/borrow flag tagged with the owner id.
//   Optional feature: define ACC_ARB_TIMEOUT_EN to abort a burst whose owner
//   stops presenting beats for TIMEOUT cycles (rsp_abort=1, partial result).
module accum_arbiter #(
   parameter int unsigned NREQ      = 4,
   parameter int unsigned DW        = 4,
   parameter int unsigned MAX_BURST = 4,
   parameter int unsigned TIMEOUT   = 8
) (
   input  logic                    Clk,
   input  logic                    nReset,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ*(DW+1)-1:0]  req_op,
   input  logic [NREQ-1:0]         req_last,
   output logic [NREQ-1:0]         gnt,
   output logic [DW:0]             acc_a,
   output logic                    acc_nrst,
   input  logic [DW-1:0]           acc_y,
   input  logic                    acc_cbf,
   output logic                    rsp_valid,
   output logic [$clog2(NREQ)-1:0] rsp_id,
   output logic [DW-1:0]           rsp_y,
   output logic                    rsp_cbf,
   output logic                    rsp_abort
);

   localparam int unsigned IW = $clog2(NREQ);
   localparam int unsigned CW = $clog2(MAX_BURST + 1);
   localparam int unsigned TW = $clog2(TIMEOUT + 1);

   localparam logic [CW-1:0]   CNT_LAST  = CW'(MAX_BURST - 1);
   localparam logic [TW-1:0]   IDLE_LAST = TW'(TIMEOUT - 1);
   localparam logic [NREQ-1:0] GNT_ONE   = NREQ'(1);
   localparam logic [IW-1:0]   ID_LAST   = IW'(NREQ - 1);

`ifdef ACC_ARB_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   // idle counter is constant zero and folds away; rsp_abort stays 0
   localparam bit TO_EN = 1'b0;
`endif

   typedef enum logic [1:0] {
      IDLE,
      CLEAR,
      RUN,
      DRAIN
   } state_t;

   state_t        state;
   logic [IW-1:0] rr;
   logic [IW-1:0] owner;
   logic [IW-1:0] pick;
   logic [IW-1:0] owner_nxt;
   logic [CW-1:0] cnt;
   logic [TW-1:0] idle_cnt;

   logic          own_req;
   logic          own_last;
   logic [DW:0]   own_op;
   logic          beat;
   logic          burst_end;
   logic          timeout_hit;

   // round-robin pick: first requesting index at or after rr, wrapping
   // (scan from farthest to nearest so the nearest hit is written last)
   always_comb begin
      int unsigned   j;
      logic [IW-1:0] idx;
      pick = rr;
      for (int unsigned k = 0; k < NREQ; k++) begin
         j   = (32'(rr) + NREQ - 1 - k) % NREQ;
         idx = IW'(j);
         if (req[idx]) pick = idx;
      end
   end

   // owner's request view, beat acceptance and burst termination
   always_comb begin
      own_req     = req[owner];
      own_last    = req_last[owner];
      own_op      = req_op[owner*(DW+1) +: DW+1];
      beat        = (state == RUN) && own_req;
      burst_end   = beat && (own_last || (cnt == CNT_LAST));
      timeout_hit = TO_EN && (state == RUN) && !own_req && (idle_cnt == IDLE_LAST);
      owner_nxt   = (owner == ID_LAST) ? '0 : owner + 1'b1;
   end

   // accumulator feed and result path: the accumulator adds on the same edge
   // that accepts a beat, so acc_a and rsp_y/rsp_cbf pass straight through
   // (gated by registered state) instead of adding a pipeline stage
   always_comb begin
      acc_a   = beat ? own_op : '0;
      rsp_y   = rsp_valid ? acc_y : '0;
      rsp_cbf = rsp_valid ? acc_cbf : 1'b0;
   end

   // burst FSM with registered grant, clear pulse and response strobe
   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         state     <= IDLE;
         gnt       <= '0;
         rr        <= '0;
         owner     <= '0;
         cnt       <= '0;
         idle_cnt  <= '0;
         acc_nrst  <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_abort <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               acc_nrst <= 1'b1;
               if (|req) begin
                  owner    <= pick;
                  acc_nrst <= 1'b0;
                  state    <= CLEAR;
               end
            end
            CLEAR: begin
               acc_nrst <= 1'b1;
               gnt      <= GNT_ONE << owner;
               idle_cnt <= '0;
               state    <= RUN;
            end
            RUN: begin
               if (beat) begin
                  cnt      <= cnt + 1'b1;
                  idle_cnt <= '0;
               end else if (TO_EN) begin
                  idle_cnt <= idle_cnt + 1'b1;
               end
               if (burst_end || timeout_hit) begin
                  gnt       <= '0;
                  rsp_valid <= 1'b1;
                  rsp_id    <= owner;
                  rsp_abort <= timeout_hit;
                  state     <= DRAIN;
               end
            end
            DRAIN: begin
               rsp_valid <= 1'b0;
               rsp_abort <= 1'b0;
               rr        <= owner_nxt;
               cnt       <= '0;
               idle_cnt  <= '0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_accum_arbiter.sv
// tb_accum_arbiter: scoreboard bench for accum_arbiter with a behavioural
// accumulator, per-requester beat queues and a round-robin reference model.
module tb_accum_arbiter;

   localparam int unsigned NREQ      = 4;
   localparam int unsigned DW        = 4;
   localparam int unsigned MAX_BURST = 4;
   localparam int unsigned TIMEOUT   = 8;
   localparam int          LIMIT     = 3000;

   logic                   Clk = 1'b0;
   logic                   nReset;
   logic [NREQ-1:0]        req;
   logic [NREQ*(DW+1)-1:0] req_op;
   logic [NREQ-1:0]        req_last;
   logic [NREQ-1:0]        gnt;
   logic [DW:0]            acc_a;
   logic                   acc_nrst;
   logic [DW-1:0]          acc_y;
   logic                   acc_cbf;
   logic                   rsp_valid;
   logic [1:0]             rsp_id;
   logic [DW-1:0]          rsp_y;
   logic                   rsp_cbf;
   logic                   rsp_abort;

   typedef struct packed { logic [4:0] op; logic last; } beat_t;
   typedef struct packed { logic [3:0] y; logic cbf; logic abort; } exp_t;

   beat_t stim [NREQ][$];
   exp_t  expq [NREQ][$];

   int checks = 0;
   int errors = 0;

   accum_arbiter #(.NREQ(NREQ), .DW(DW), .MAX_BURST(MAX_BURST), .TIMEOUT(TIMEOUT)) dut (
      .Clk(Clk), .nReset(nReset), .req(req), .req_op(req_op), .req_last(req_last),
      .gnt(gnt), .acc_a(acc_a), .acc_nrst(acc_nrst), .acc_y(acc_y), .acc_cbf(acc_cbf),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_y(rsp_y), .rsp_cbf(rsp_cbf),
      .rsp_abort(rsp_abort)
   );

   always #5 Clk = ~Clk;

   // behavioural accumulator: Y <= Y +/- A each rising edge, async clear
   always @(posedge Clk or negedge acc_nrst) begin
      if (!acc_nrst) begin
         acc_y   <= '0;
         acc_cbf <= 1'b0;
      end else if (acc_a[DW]) begin
         acc_y   <= acc_y - acc_a[DW-1:0];
         acc_cbf <= (acc_y < acc_a[DW-1:0]);
      end else begin
         {acc_cbf, acc_y} <= {1'b0, acc_y} + {1'b0, acc_a[DW-1:0]};
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h t=%0t", name, got, want, $time);
      end
   endtask

   task automatic push_beat(input int id, input logic [4:0] op, input logic last);
      beat_t b;
      b.op   = op;
      b.last = last;
      stim[id].push_back(b);
   endtask

   task automatic push_exp(input int id, input int y, input int c, input int ab);
      exp_t e;
      e.y     = 4'(y);
      e.cbf   = c[0];
      e.abort = ab[0];
      expq[id].push_back(e);
   endtask

   // reference: a burst splits into grants of at most MAX_BURST beats; each
   // grant starts from a cleared accumulator and reports (sum mod 16, last C/B)
   task automatic add_burst(input int id, input int len);
      int y, c, n, v;
      logic [4:0] op;
      y = 0; c = 0; n = 0;
      for (int b = 0; b < len; b++) begin
         op = 5'($urandom);
         push_beat(id, op, b == len - 1);
         v = int'(op[3:0]);
         if (op[4]) begin
            c = (y < v) ? 1 : 0;
            y = (y - v + 16) % 16;
         end else begin
            c = (y + v > 15) ? 1 : 0;
            y = (y + v) % 16;
         end
         n++;
         if (b == len - 1 || n == MAX_BURST) begin
            push_exp(id, y, c, 0);
            y = 0; c = 0; n = 0;
         end
      end
   endtask

   function automatic bit busy();
      busy = 1'b0;
      for (int i = 0; i < NREQ; i++)
         if (stim[i].size() != 0 || expq[i].size() != 0) busy = 1'b1;
   endfunction

   task automatic wait_drain(input string tag);
      int n;
      n = 0;
      while (busy() && n < LIMIT) begin
         @(negedge Clk);
         n++;
      end
      chk({"drain_", tag}, (n < LIMIT) ? 1 : 0, 1);
      if (n >= LIMIT)
         for (int i = 0; i < NREQ; i++) begin
            stim[i].delete();
            expq[i].delete();
         end
      repeat (2) @(negedge Clk);
   endtask

   task automatic drive();
      for (int i = 0; i < NREQ; i++) begin
         if (stim[i].size() != 0) begin
            req[i]               = 1'b1;
            req_op[i*(DW+1) +: 5] = stim[i][0].op;
            req_last[i]          = stim[i][0].last;
         end else begin
            req[i]               = 1'b0;
            req_op[i*(DW+1) +: 5] = '0;
            req_last[i]          = 1'b0;
         end
      end
   endtask

   // requester side: retire beats accepted on the previous edge, present heads
   initial begin
      logic [NREQ-1:0] acc_mask;
      acc_mask = '0;
      forever begin
         @(negedge Clk);
         for (int i = 0; i < NREQ; i++)
            if (acc_mask[i] && stim[i].size() != 0) void'(stim[i].pop_front());
         drive();
         acc_mask = nReset ? (req & gnt) : '0;
      end
   end

   // monitor: grant order, clear pulse, turnaround, acc_a routing, responses
   initial begin
      logic [NREQ-1:0] prev_gnt;
      logic            prev_rsp, nh1, nh2, pend, found;
      int              ptr, owner, low, eo, j;
      exp_t            e;
      prev_gnt = '0; prev_rsp = 0; nh1 = 0; nh2 = 0; pend = 0;
      ptr = 0; owner = 0; low = 0; eo = 0;
      forever begin
         @(negedge Clk);
         #1;
         if (!nReset) begin
            prev_gnt = '0; prev_rsp = 0; nh1 = 0; nh2 = 0; pend = 0;
            ptr = 0; owner = 0; low = 0;
         end else begin
            if (gnt != '0 && prev_gnt == '0) begin
               found = 0;
               for (int k = 0; k < NREQ; k++) begin
                  j = (ptr + k) % NREQ;
                  if (!found && stim[j].size() != 0) begin
                     found = 1;
                     eo = j;
                  end
               end
               chk("grant_had_pending", found, 1);
               chk("gnt_round_robin", gnt, 32'(1) << eo);
               owner = eo;
               chk("clear_pulse", {nh2, nh1, acc_nrst}, 3'b101);
               if (pend) chk("turnaround", low, 3);
               low = 0;
            end else if (gnt == '0) begin
               low++;
            end
            if (gnt != '0) begin
               chk("gnt_onehot", gnt, 32'(1) << owner);
               chk("acc_a_route", acc_a, req[owner] ? req_op[owner*(DW+1) +: 5] : 5'd0);
            end else begin
               chk("acc_a_idle", acc_a, 0);
            end
            if (gnt == '0 && prev_gnt != '0) begin
               pend = 0;
               for (int i = 0; i < NREQ; i++) if (stim[i].size() != 0) pend = 1;
            end
            if (rsp_valid) begin
               chk("rsp_one_cycle", prev_rsp, 0);
               chk("rsp_gnt_low", gnt, 0);
               chk("rsp_id", rsp_id, owner);
               if (expq[rsp_id].size() == 0) begin
                  chk("rsp_unexpected", 1, 0);
               end else begin
                  e = expq[rsp_id].pop_front();
                  chk("rsp_y", rsp_y, e.y);
                  chk("rsp_cbf", rsp_cbf, e.cbf);
                  chk("rsp_abort", rsp_abort, e.abort);
               end
               ptr = (owner + 1) % NREQ;
            end
            prev_gnt = gnt;
            prev_rsp = rsp_valid;
            nh2 = nh1;
            nh1 = acc_nrst;
         end
      end
   end

   // stimulus sequence
   initial begin
      int n;
      nReset   = 1'b0;
      req      = '0;
      req_op   = '0;
      req_last = '0;
      repeat (3) @(negedge Clk);
      chk("rst_gnt", gnt, 0);
      chk("rst_acc_nrst", acc_nrst, 0);
      chk("rst_acc_a", acc_a, 0);
      chk("rst_rsp", {rsp_valid, rsp_id, rsp_y, rsp_cbf, rsp_abort}, 0);
      nReset = 1'b1;
      @(negedge Clk);
      chk("nrst_release", acc_nrst, 1);
      repeat (2) @(negedge Clk);

      // req1: +3 +5 -2(last) -> 6, cbf 0
      push_beat(1, 5'h03, 0); push_beat(1, 5'h05, 0); push_beat(1, 5'h12, 1);
      push_exp(1, 6, 0, 0);
      wait_drain("d1");

      // req0: +9 +9(last) -> 2, cbf 1 ; then -1(last) -> 15, cbf 1
      push_beat(0, 5'h09, 0); push_beat(0, 5'h09, 1); push_beat(0, 5'h11, 1);
      push_exp(0, 2, 1, 0); push_exp(0, 15, 1, 0);
      wait_drain("d2");

      // req0 and req2 with one-beat bursts alternate
      push_beat(0, 5'h01, 1); push_beat(0, 5'h02, 1);
      push_beat(2, 5'h03, 1); push_beat(2, 5'h04, 1);
      push_exp(0, 1, 0, 0); push_exp(0, 2, 0, 0);
      push_exp(2, 3, 0, 0); push_exp(2, 4, 0, 0);
      wait_drain("d3");

      // req3: six +1 beats -> forced drain at 4, remainder gives 2
      for (int b = 0; b < 6; b++) push_beat(3, 5'h01, b == 5);
      push_exp(3, 4, 0, 0); push_exp(3, 2, 0, 0);
      wait_drain("d4");

      // reset during the second beat of a burst: no response for it
      for (int b = 0; b < 3; b++) push_beat(2, 5'h01, b == 2);
      n = 0;
      while (gnt[2] !== 1'b1 && n < 50) begin
         @(negedge Clk);
         n++;
      end
      chk("kill_grant_seen", (n < 50) ? 1 : 0, 1);
      @(negedge Clk);
      #2;
      nReset = 1'b0;
      stim[2].delete();
      req = '0; req_op = '0; req_last = '0;
      #1;
      chk("kill_gnt", gnt, 0);
      chk("kill_acc_nrst", acc_nrst, 0);
      chk("kill_rsp_valid", rsp_valid, 0);
      chk("kill_acc_y", acc_y, 0);
      repeat (2) @(negedge Clk);
      nReset = 1'b1;
      repeat (3) @(negedge Clk);
      chk("recover_acc_nrst", acc_nrst, 1);
      chk("recover_gnt", gnt, 0);

`ifdef ACC_ARB_TIMEOUT_EN
      // req2: +7 then no more beats -> abort with partial result 7
      push_beat(2, 5'h07, 0);
      push_exp(2, 7, 0, 1);
      wait_drain("timeout");
`endif

      // randomized phases
      for (int p = 0; p < 30; p++) begin
         for (int i = 0; i < NREQ; i++) begin
            n = int'($urandom_range(0, 2));
            for (int b = 0; b < n; b++) add_burst(i, int'($urandom_range(1, 7)));
         end
         wait_drain("rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #800000;
      $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule
